// File: rtl/cd_config_multi.sv
`default_nettype none
// ============================================================================
// cd_config_multi : N_CH clock-divider channels with shadowed, wrap-committed
//                   limit configuration through one shared write port.
// Revision 1.0
// ============================================================================
module cd_config_multi #(
   parameter int                          N_CH              = 4,
   parameter int                          WIDTH_CONFIG_ADDR = 3,
   parameter int                          WIDTH_LIMIT       = 16,
   parameter logic [N_CH*WIDTH_LIMIT-1:0] RST_LIMIT         = {N_CH{16'd5207}}
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WIDTH_CONFIG_ADDR-1:0]  c_addr,
   input  logic [WIDTH_LIMIT-1:0]        c_data,
   input  logic                          c_valid,
   input  logic                          c_immediate,
   output logic [N_CH-1:0]               c_ready,
   output logic                          c_error,
   output logic [N_CH*WIDTH_LIMIT-1:0]   limit,
   output logic [N_CH-1:0]               tick,
   output logic [N_CH-1:0]               clk_div
);

   logic [N_CH-1:0] w_sel;
   logic [N_CH-1:0] w_ready;
   logic            w_hit;
   logic            w_busy;
   logic            w_accept;
   logic            err_q;

   // An out-of-range address selects no channel, so it is rejected via w_hit.
   assign w_hit    = |w_sel;
   assign w_busy   = |(w_sel & ~w_ready);
   assign w_accept = c_valid & w_hit & ~w_busy & (c_data != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= c_valid & ~w_accept;
      end
   end

   assign c_error = err_q;
   assign c_ready = w_ready;

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         logic [WIDTH_LIMIT-1:0] cnt_q;
         logic [WIDTH_LIMIT-1:0] active_q;
         logic [WIDTH_LIMIT-1:0] shadow_q;
         logic                   ready_q;
         logic                   tick_q;
         logic                   clk_div_q;
         logic                   w_wrap;
         logic                   w_imm;
         logic                   w_def;

         assign w_sel[i] = (c_addr == WIDTH_CONFIG_ADDR'(i));
         assign w_wrap   = (cnt_q == active_q);
         assign w_imm    = w_accept & w_sel[i] & c_immediate;
         assign w_def    = w_accept & w_sel[i] & ~c_immediate;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q     <= '0;
               active_q  <= RST_LIMIT[i*WIDTH_LIMIT +: WIDTH_LIMIT];
               shadow_q  <= RST_LIMIT[i*WIDTH_LIMIT +: WIDTH_LIMIT];
               ready_q   <= 1'b1;
               tick_q    <= 1'b0;
               clk_div_q <= 1'b0;
            end else if (w_imm) begin
               // Immediate write restarts the channel and overrides any wrap.
               active_q  <= c_data;
               cnt_q     <= '0;
               tick_q    <= 1'b0;
               clk_div_q <= 1'b0;
            end else begin
               if (w_wrap) begin
                  cnt_q     <= '0;
                  tick_q    <= 1'b1;
                  clk_div_q <= ~clk_div_q;
                  if (!ready_q) begin
                     active_q <= shadow_q;
                     ready_q  <= 1'b1;
                  end
               end else begin
                  cnt_q  <= cnt_q + 1'b1;
                  tick_q <= 1'b0;
               end
               // Only accepted when idle, so it never collides with a commit.
               if (w_def) begin
                  shadow_q <= c_data;
                  ready_q  <= 1'b0;
               end
            end
         end

         assign w_ready[i]                          = ready_q;
         assign tick[i]                             = tick_q;
         assign clk_div[i]                          = clk_div_q;
         assign limit[i*WIDTH_LIMIT +: WIDTH_LIMIT] = active_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cd_config_multi.sv
`default_nettype none
// ============================================================================
// tb_cd_config_multi : directed self-checking bench for cd_config_multi.
// Revision 1.0
// ============================================================================
module tb_cd_config_multi;

   localparam int          N_CH  = 4;
   localparam int          WA    = 3;
   localparam int          WL    = 16;
   localparam logic [63:0] RST_L = {16'd5, 16'd7, 16'd9, 16'd3};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [WA-1:0] c_addr = '0;
   logic [WL-1:0] c_data = '0;
   logic          c_valid = 1'b0;
   logic          c_immediate = 1'b0;
   logic [3:0]    c_ready;
   logic          c_error;
   logic [63:0]   limit;
   logic [3:0]    tick;
   logic [3:0]    clk_div;

   int n_checks = 0;
   int n_errors = 0;
   int n;

   cd_config_multi #(
      .N_CH              (N_CH),
      .WIDTH_CONFIG_ADDR (WA),
      .WIDTH_LIMIT       (WL),
      .RST_LIMIT         (RST_L)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .c_addr      (c_addr),
      .c_data      (c_data),
      .c_valid     (c_valid),
      .c_immediate (c_immediate),
      .c_ready     (c_ready),
      .c_error     (c_error),
      .limit       (limit),
      .tick        (tick),
      .clk_div     (clk_div)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Counts negedges until tick[ch] is seen high; a missed tick is a failure.
   task automatic wait_tick(input int ch, input int max, output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!tick[ch] && cnt < max);
      check($sformatf("tick_seen_ch%0d", ch), {63'd0, tick[ch]}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready",  {60'd0, c_ready}, 64'hF);
      check("rst_tick",   {60'd0, tick},    64'h0);
      check("rst_clkdiv", {60'd0, clk_div}, 64'h0);
      check("rst_error",  {63'd0, c_error}, 64'h0);
      check("rst_limit",  limit,            RST_L);
      rst = 1'b0;

      // Channel 0 free-running at limit 3
      wait_tick(0, 10, n);
      check("ch0_first_tick", n, 4);
      check("ch0_clkdiv_hi", {63'd0, clk_div[0]}, 64'd1);
      wait_tick(0, 10, n);
      check("ch0_period", n, 4);
      check("ch0_clkdiv_lo", {63'd0, clk_div[0]}, 64'd0);

      // Deferred write on ch1 at cnt=2, then a rejected second write
      wait_tick(1, 20, n);
      repeat (2) @(negedge clk);
      c_valid = 1'b1; c_addr = 3'd1; c_data = 16'd4; c_immediate = 1'b0;
      @(negedge clk);
      check("def_ready_low", {63'd0, c_ready[1]}, 64'd0);
      check("def_no_error",  {63'd0, c_error},    64'd0);
      check("def_limit_old", {48'd0, limit[31:16]}, 64'd9);
      c_data = 16'd8;
      @(negedge clk);
      check("busy_error",      {63'd0, c_error},    64'd1);
      check("busy_ready_low",  {63'd0, c_ready[1]}, 64'd0);
      c_valid = 1'b0;
      @(negedge clk);
      check("busy_error_pulse", {63'd0, c_error}, 64'd0);
      wait_tick(1, 20, n);
      check("def_old_period_tail", n, 5);
      check("def_commit_ready", {63'd0, c_ready[1]}, 64'd1);
      check("def_commit_limit", {48'd0, limit[31:16]}, 64'd4);
      wait_tick(1, 20, n);
      check("def_new_period", n, 5);
      check("def_limit_kept", {48'd0, limit[31:16]}, 64'd4);

      // Immediate write on ch2 mid-count while clk_div[2] is high
      wait_tick(2, 20, n);
      if (!clk_div[2]) wait_tick(2, 20, n);
      repeat (3) @(negedge clk);
      c_valid = 1'b1; c_addr = 3'd2; c_data = 16'd2; c_immediate = 1'b1;
      @(negedge clk);
      c_valid = 1'b0; c_immediate = 1'b0;
      check("imm_no_tick",  {63'd0, tick[2]},    64'd0);
      check("imm_clkdiv0",  {63'd0, clk_div[2]}, 64'd0);
      check("imm_ready",    {63'd0, c_ready[2]}, 64'd1);
      check("imm_limit",    {48'd0, limit[47:32]}, 64'd2);
      check("imm_no_error", {63'd0, c_error},    64'd0);
      wait_tick(2, 20, n);
      check("imm_first_tick", n, 3);
      check("imm_clkdiv_hi", {63'd0, clk_div[2]}, 64'd1);

      // Illegal writes: out-of-range address, zero data
      c_valid = 1'b1; c_addr = 3'd5; c_data = 16'd3;
      @(negedge clk);
      check("bad_addr_error", {63'd0, c_error}, 64'd1);
      check("bad_addr_limit", limit, {16'd5, 16'd2, 16'd4, 16'd3});
      check("bad_addr_ready", {60'd0, c_ready}, 64'hF);
      c_addr = 3'd0; c_data = 16'd0;
      @(negedge clk);
      check("zero_data_error", {63'd0, c_error}, 64'd1);
      check("zero_data_ready", {60'd0, c_ready}, 64'hF);
      c_valid = 1'b0;
      @(negedge clk);
      check("idle_no_error", {63'd0, c_error}, 64'd0);
      check("zero_data_limit", limit, {16'd5, 16'd2, 16'd4, 16'd3});
      wait_tick(0, 10, n);
      wait_tick(0, 10, n);
      check("ch0_after_bad", n, 4);

      // Reset while ch3 has a pending update
      c_valid = 1'b1; c_addr = 3'd3; c_data = 16'd9; c_immediate = 1'b0;
      @(negedge clk);
      c_valid = 1'b0;
      check("ch3_pending", {63'd0, c_ready[3]}, 64'd0);
      rst = 1'b1;
      #1;
      check("arst_ready",  {60'd0, c_ready}, 64'hF);
      check("arst_limit",  limit,            RST_L);
      check("arst_tick",   {60'd0, tick},    64'h0);
      check("arst_clkdiv", {60'd0, clk_div}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      wait_tick(3, 20, n);
      check("ch3_post_rst_tick", n, 6);
      wait_tick(3, 20, n);
      check("ch3_post_rst_period", n, 6);
      check("ch3_pending_dropped", {48'd0, limit[63:48]}, 64'd5);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
